cex_controller: RTL and testbench

Conditional-execution sequencer for the multi-cycle XMakina core. It sits directly downstream of the program status register and consumes its 16-bit PSW output. On a CEX instruction it evaluates a condition code against the C/Z/N/V flags, then runs the following instruction stream as a true block and a false block of programmable length. It drives a per-instruction execute enable back to the control unit.

---
 rtl/xm_pkg.sv | 20 ++
 rtl/cex_cond_eval.sv | 36 +++
 rtl/cex_controller.sv | 93 +++++++++
 tb/tb_cex_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared XMakina core types: condition codes, PSW flag positions, CEX sequencer states.
package xm_pkg;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, TR, FL
    } cex_cond_t;

    typedef enum int unsigned {
        PSW_C = 0,
        PSW_Z = 1,
        PSW_N = 2,
        PSW_V = 3
    } psw_bit_t;

    typedef enum logic [2:0] {
        IDLE, RUN_T, SKIP_F, SKIP_T, RUN_F
    } cex_state_t;

endpackage

// File: rtl/cex_cond_eval.sv
// Combinational condition-code evaluator. The branch unit uses it for conditional branches too.
module cex_cond_eval
    import xm_pkg::*;
(
    input  cex_cond_t cond,
    input  logic      c,
    input  logic      z,
    input  logic      n,
    input  logic      v,
    output logic      result
);

    always_comb begin
        result = 1'b0;
        case (cond)
            EQ: result = z;
            NE: result = !z;
            CS: result = c;
            CC: result = !c;
            MI: result = n;
            PL: result = !n;
            VS: result = v;
            VC: result = !v;
            HI: result = c && !z;
            LS: result = !c || z;
            GE: result = (n == v);
            LT: result = (n != v);
            GT: result = !z && (n == v);
            LE: result = z || (n != v);
            TR: result = 1'b1;
            FL: result = 1'b0;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/cex_controller.sv
// Conditional-execution sequencer: runs a true block then a false block after a CEX,
// gating write-back through exec_en.
module cex_controller
    import xm_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      psw_in,
    input  logic             cex_load,
    input  logic [3:0]       cex_cond,
    input  logic [CNT_W-1:0] cex_t_cnt,
    input  logic [CNT_W-1:0] cex_f_cnt,
    input  logic             instr_done,
    input  logic             cancel,
    output logic             exec_en,
    output logic             cex_active,
    output logic             cond_true
);

    cex_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, f_cnt_q, f_cnt_n;
    logic             cond_n, cond_res;
    logic             unused_psw;

    assign unused_psw = ^psw_in[15:4];

    cex_cond_eval u_eval (
        .cond   (cex_cond_t'(cex_cond)),
        .c      (psw_in[PSW_C]),
        .z      (psw_in[PSW_Z]),
        .n      (psw_in[PSW_N]),
        .v      (psw_in[PSW_V]),
        .result (cond_res)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        f_cnt_n = f_cnt_q;
        cond_n  = cond_true;
        if (cancel) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (cex_load && exec_en) begin
            // Zero-length blocks are resolved here so the counter never has to wrap.
            cond_n  = cond_res;
            f_cnt_n = cex_f_cnt;
            if (cex_t_cnt != '0) begin
                state_n = cond_res ? RUN_T : SKIP_T;
                cnt_n   = cex_t_cnt;
            end else if (cex_f_cnt != '0) begin
                state_n = cond_res ? SKIP_F : RUN_F;
                cnt_n   = cex_f_cnt;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else if (instr_done && state != IDLE) begin
            if (cnt == CNT_W'(1)) begin
                if ((state == RUN_T || state == SKIP_T) && f_cnt_q != '0) begin
                    state_n = (state == RUN_T) ? SKIP_F : RUN_F;
                    cnt_n   = f_cnt_q;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f_cnt_q    <= '0;
            cond_true  <= 1'b0;
            exec_en    <= 1'b1;
            cex_active <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            f_cnt_q    <= f_cnt_n;
            cond_true  <= cond_n;
            exec_en    <= (state_n == IDLE) || (state_n == RUN_T) || (state_n == RUN_F);
            cex_active <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_cex_controller.sv
// Bench for cex_controller: queue-of-enables reference model plus directed literal checks.
module tb_cex_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] psw_in = '0;
    logic        cex_load = 1'b0;
    logic [3:0]  cex_cond = '0;
    logic [2:0]  cex_t_cnt = '0;
    logic [2:0]  cex_f_cnt = '0;
    logic        instr_done = 1'b0;
    logic        cancel = 1'b0;
    logic        exec_en, cex_active, cond_true;

    int total = 0;
    int bad = 0;

    cex_controller #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst), .psw_in(psw_in), .cex_load(cex_load), .cex_cond(cex_cond),
        .cex_t_cnt(cex_t_cnt), .cex_f_cnt(cex_f_cnt), .instr_done(instr_done),
        .cancel(cancel), .exec_en(exec_en), .cex_active(cex_active), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    // Model: an accepted CEX becomes a queue holding one enable bit per upcoming instruction.
    bit q[$];
    bit m_cond = 1'b0;
    bit seen_rst = 1'b0;

    function automatic bit model_cond(input logic [3:0] code, input logic [15:0] p);
        bit c, z, n, v;
        c = p[0]; z = p[1]; n = p[2]; v = p[3];
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c & !z;
            4'd9:  return !c | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_exec();
        return (q.size() == 0) ? 1'b1 : q[0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_cond = 1'b0;
            seen_rst = 1'b1;
        end else if (cancel) begin
            q.delete();
        end else if (cex_load && m_exec()) begin
            m_cond = model_cond(cex_cond, psw_in);
            q.delete();
            for (int i = 0; i < int'(cex_t_cnt); i++) q.push_back(m_cond);
            for (int i = 0; i < int'(cex_f_cnt); i++) q.push_back(!m_cond);
        end else if (instr_done && q.size() != 0) begin
            void'(q.pop_front());
        end
        #1;
        if (seen_rst) begin
            total++;
            if (exec_en !== m_exec()) begin
                bad++;
                $display("FAIL model exec_en t=%0t got=%b want=%b", $time, exec_en, m_exec());
            end
            total++;
            if (cex_active !== (q.size() != 0)) begin
                bad++;
                $display("FAIL model cex_active t=%0t got=%b want=%b", $time, cex_active, q.size() != 0);
            end
            total++;
            if (cond_true !== m_cond) begin
                bad++;
                $display("FAIL model cond_true t=%0t got=%b want=%b", $time, cond_true, m_cond);
            end
        end
    end

    task automatic lit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, return on the following negedge.
    task automatic step(input logic ld, input logic [3:0] cc, input logic [2:0] t,
                        input logic [2:0] f, input logic dn, input logic cn);
        cex_load = ld; cex_cond = cc; cex_t_cnt = t; cex_f_cnt = f;
        instr_done = dn; cancel = cn;
        @(negedge clk);
        cex_load = 1'b0; instr_done = 1'b0; cancel = 1'b0;
    endtask

    task automatic done1();
        step(1'b0, 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [4:0] seq_eq;
        @(negedge clk);
        rst = 1'b1; step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        lit("reset exec_en", exec_en, 1'b1);
        lit("reset cex_active", cex_active, 1'b0);
        lit("reset cond_true", cond_true, 1'b0);

        // EQ, Z=1, t=2 f=3: enables 1,1,0,0,0 then idle
        psw_in = 16'h0002;
        step(1, 4'd0, 3'd2, 3'd3, 0, 0);
        lit("eq cond_true", cond_true, 1'b1);
        lit("eq exec0", exec_en, 1'b1);
        lit("eq active", cex_active, 1'b1);
        seq_eq = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            done1();
            lit($sformatf("eq exec%0d", i + 1), exec_en, seq_eq[4 - i]);
        end
        lit("eq idle", cex_active, 1'b0);

        // NE, Z=1, t=2 f=1
        step(1, 4'd1, 3'd2, 3'd1, 0, 0);
        lit("ne cond_true", cond_true, 1'b0);
        lit("ne exec0", exec_en, 1'b0);
        done1(); lit("ne exec1", exec_en, 1'b0);
        done1(); lit("ne exec2", exec_en, 1'b1);
        lit("ne active2", cex_active, 1'b1);
        done1(); lit("ne idle", cex_active, 1'b0);

        // GT, N=V=1 Z=0, t=0 f=2: straight to false skip
        psw_in = 16'hF00C;
        step(1, 4'd12, 3'd0, 3'd2, 0, 0);
        lit("gt cond_true", cond_true, 1'b1);
        lit("gt skip exec", exec_en, 1'b0);
        done1(); lit("gt skip2 exec", exec_en, 1'b0);
        done1(); lit("gt idle", cex_active, 1'b0);
        step(1, 4'd15, 3'd0, 3'd0, 0, 0);
        lit("fl idle", cex_active, 1'b0);
        lit("fl cond_true", cond_true, 1'b0);

        // CEX inside a skip block is ignored
        psw_in = 16'h0001;
        step(1, 4'd3, 3'd2, 3'd1, 0, 0);
        lit("skipt exec", exec_en, 1'b0);
        step(1, 4'd14, 3'd0, 3'd0, 0, 0);
        lit("skipt ignore active", cex_active, 1'b1);
        lit("skipt ignore cond", cond_true, 1'b0);
        done1(); lit("skipt dec exec", exec_en, 1'b0);
        done1(); lit("skipt runf exec", exec_en, 1'b1);
        done1(); lit("skipt end", cex_active, 1'b0);

        // CEX inside a run block restarts
        step(1, 4'd14, 3'd3, 3'd0, 0, 0);
        done1();
        step(1, 4'd15, 3'd1, 3'd2, 0, 0);
        lit("restart exec", exec_en, 1'b0);
        lit("restart cond", cond_true, 1'b0);
        done1(); lit("restart runf", exec_en, 1'b1);
        done1(); lit("restart runf2", cex_active, 1'b1);
        done1(); lit("restart end", cex_active, 1'b0);

        // load coincident with done: the done is not counted
        step(1, 4'd14, 3'd1, 3'd0, 0, 0);
        step(1, 4'd14, 3'd2, 3'd0, 1, 0);
        done1(); lit("coincide still run", cex_active, 1'b1);
        done1(); lit("coincide end", cex_active, 1'b0);

        // cancel mid-RUN_F with two left
        step(1, 4'd15, 3'd0, 3'd3, 0, 0);
        done1();
        step(0, 0, 0, 0, 0, 1);
        lit("cancel exec", exec_en, 1'b1);
        lit("cancel active", cex_active, 1'b0);

        // cancel keeps cond_true
        step(1, 4'd14, 3'd2, 3'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        lit("cancel keeps cond", cond_true, 1'b1);

        // rst with cancel during SKIP_T
        step(1, 4'd3, 3'd3, 3'd0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        lit("rst exec", exec_en, 1'b1);
        lit("rst active", cex_active, 1'b0);
        lit("rst cond", cond_true, 1'b0);

        // random phase, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            psw_in = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(($urandom_range(0, 3) == 0), 4'($urandom), 3'($urandom), 3'($urandom),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 39) == 0));
        end
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
